key_pulse_conditioner: RTL and testbench

Conditions the raw, bouncy, active-low DE1-SoC pushbuttons into clean per-key signals for the FIFO's push/pop inputs. For each key it provides a debounced "held" level and a single-cycle pulse per press, so one physical press produces exactly one push or pop. An optional hold-to-repeat feature generates further pulses while a key stays down. It sits between the board KEY pins and the FIFO in the board top level, one instance covering every conditioned key.

---
 rtl/key_pulse_conditioner.sv | 114 +++++++++++
 tb/tb_key_pulse_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_pulse_conditioner                                                      |
// | Debounces active-low pushbuttons into held levels and one-cycle strobes,   |
// | with optional hold-to-repeat.                                              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module key_pulse_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_rcnt;
    logic          r_pressed;
    logic          r_pulse;
    logic [RW-1:0] w_rnext;

    assign w_rnext    = r_rcnt + 1'b1;
    assign pressed[i] = r_pressed;
    assign pulse[i]   = r_pulse;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_rcnt    <= '0;
        r_pressed <= 1'b0;
        r_pulse   <= 1'b0;
      end else begin
        r_sync1 <= ~key_n[i];
        r_sync2 <= r_sync1;
        r_pulse <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (r_sync2) begin
              r_state <= ST_PRESS_WAIT;
              r_cnt   <= CW'(1);
            end
          end
          ST_PRESS_WAIT: begin
            if (!r_sync2) begin
              r_state <= ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= ST_HELD;
              r_pressed <= 1'b1;
              r_pulse   <= 1'b1;
              r_rcnt    <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_HELD: begin
            if (!r_sync2) begin
              r_state <= ST_RELEASE_WAIT;
              r_cnt   <= CW'(1);
            end else if (REPEAT_EN) begin
              // After the first repeat the counter folds back to the delay
              // value, so later repeats land every REPEAT_PERIOD cycles.
              if (w_rnext == RPT_WRAP) begin
                r_rcnt  <= RPT_FIRST;
                r_pulse <= 1'b1;
              end else begin
                r_rcnt  <= w_rnext;
                r_pulse <= (w_rnext == RPT_FIRST);
              end
            end
          end
          ST_RELEASE_WAIT: begin
            if (r_sync2) begin
              r_state <= ST_HELD;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= ST_IDLE;
              r_pressed <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_pulse_conditioner                                                   |
// | Scoreboard bench: expected pulses queued by stimulus, checked by monitor.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_key_pulse_conditioner;

  typedef struct {
    int         cyc;
    logic [1:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_n, key_n_r;
  logic [1:0] pressed, pulse, pressed_r, pulse_r;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  exp_t       q[$];
  exp_t       qr[$];

  key_pulse_conditioner #(
    .N_KEYS(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(rst_n), .key_n(key_n), .pressed(pressed), .pulse(pulse)
  );

  key_pulse_conditioner #(
    .N_KEYS(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_r (
    .clk(clk), .reset(rst_n), .key_n(key_n_r), .pressed(pressed_r), .pulse(pulse_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every nonzero pulse must match the head of its queue at the queued cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL pulse_missed: cyc %0d got 00 expected %b", e.cyc, e.v);
      end
      if (pulse !== 2'b00) begin
        n_tests++;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          if (e.v !== pulse) begin
            n_fail++;
            $display("FAIL pulse_value: cyc %0d got %b expected %b", cyc, pulse, e.v);
          end
        end else begin
          n_fail++;
          $display("FAIL pulse_unexpected: cyc %0d got %b expected 00", cyc, pulse);
        end
      end
      while (qr.size() > 0 && qr[0].cyc < cyc) begin
        e = qr.pop_front();
        n_tests++; n_fail++;
        $display("FAIL rpt_missed: cyc %0d got 00 expected %b", e.cyc, e.v);
      end
      if (pulse_r !== 2'b00) begin
        n_tests++;
        if (qr.size() > 0 && qr[0].cyc == cyc) begin
          e = qr.pop_front();
          if (e.v !== pulse_r) begin
            n_fail++;
            $display("FAIL rpt_value: cyc %0d got %b expected %b", cyc, pulse_r, e.v);
          end
        end else begin
          n_fail++;
          $display("FAIL rpt_unexpected: cyc %0d got %b expected 00", cyc, pulse_r);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cyc %0d got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [1:0] v);
    q.push_back('{cyc: c, v: v});
  endtask

  task automatic push_r(input int c, input logic [1:0] v);
    qr.push_back('{cyc: c, v: v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n   = 1'b0;
    key_n   = 2'b11;
    key_n_r = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_pressed", pressed, 2'b00);
    chk("reset_pulse", pulse, 2'b00);
    chk("reset_pressed_r", pressed_r, 2'b00);
    chk("reset_pulse_r", pulse_r, 2'b00);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press and clean release of key 0
    e0 = cyc + 1; key_n = 2'b10; push(e0 + 5, 2'b01);
    wait_to(e0 + 4); chk("press_before", pressed, 2'b00);
    wait_to(e0 + 5); chk("press_held", pressed, 2'b01);
    wait_to(e0 + 10);
    e0 = cyc + 1; key_n = 2'b11;
    wait_to(e0 + 4); chk("release_before", pressed, 2'b01);
    wait_to(e0 + 5); chk("release_done", pressed, 2'b00);
    repeat (4) @(negedge clk);

    // Bouncing press, then stable
    key_n = 2'b10; @(negedge clk);
    key_n = 2'b11; @(negedge clk);
    key_n = 2'b10; @(negedge clk);
    key_n = 2'b11; @(negedge clk);
    e0 = cyc + 1; key_n = 2'b10; push(e0 + 5, 2'b01);
    wait_to(e0 + 4); chk("bounce_before", pressed, 2'b00);
    wait_to(e0 + 6); chk("bounce_held", pressed, 2'b01);

    // Release bounce from HELD: 2 released cycles must not drop pressed
    key_n = 2'b11; repeat (2) @(negedge clk);
    key_n = 2'b10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("relbounce_held", pressed, 2'b01);
    end
    e0 = cyc + 1; key_n = 2'b11;
    wait_to(e0 + 4); chk("relbounce_rel_before", pressed, 2'b01);
    wait_to(e0 + 5); chk("relbounce_rel_done", pressed, 2'b00);
    repeat (4) @(negedge clk);

    // Simultaneous press; release only key 1
    e0 = cyc + 1; key_n = 2'b00; push(e0 + 5, 2'b11);
    wait_to(e0 + 5); chk("simul_held", pressed, 2'b11);
    wait_to(e0 + 8);
    e0 = cyc + 1; key_n = 2'b10;
    wait_to(e0 + 5); chk("simul_key1_released", pressed, 2'b01);
    key_n = 2'b11;
    repeat (8) @(negedge clk);
    chk("simul_all_released", pressed, 2'b00);

    // Hold-to-repeat on the repeat-enabled instance
    e0 = cyc + 1; key_n_r = 2'b10;
    push_r(e0 + 5, 2'b01);  push_r(e0 + 13, 2'b01); push_r(e0 + 16, 2'b01);
    push_r(e0 + 19, 2'b01); push_r(e0 + 22, 2'b01); push_r(e0 + 25, 2'b01);
    wait_to(e0 + 25); chk("rpt_held", pressed_r, 2'b01);
    key_n_r = 2'b11;
    repeat (20) @(negedge clk);
    chk("rpt_released", pressed_r, 2'b00);

    // Reset while held; key still down gives a fresh press pulse
    e0 = cyc + 1; key_n = 2'b10; push(e0 + 5, 2'b01);
    wait_to(e0 + 7); chk("rst_pre_held", pressed, 2'b01);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pressed", pressed, 2'b00);
    chk("rst_pulse", pulse, 2'b00);
    e0 = cyc + 1; rst_n = 1'b1; push(e0 + 5, 2'b01);
    wait_to(e0 + 4); chk("rst_repress_before", pressed, 2'b00);
    wait_to(e0 + 5); chk("rst_repress_held", pressed, 2'b01);
    key_n = 2'b11;
    repeat (10) @(negedge clk);

    n_tests++;
    if (q.size() != 0 || qr.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", q.size(), qr.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
